ysyx_24090018_exec_ctrl: RTL
============================

# ysyx_24090018_exec_ctrl

Multi-cycle sequencing controller for the single-issue core. It owns the PC, fetches instructions over a request/valid handshake, holds the instruction stable for the decode and execute datapath, and stalls for load/store completion. It then commits register write-back and the next PC, and halts the core on `ebreak`, illegal opcodes or bus timeout. It sits between instruction/data memory and the IDU/EXU/register file.

## Interface
- Clocking: one clock; reset is synchronous and active-low (`clk`, `rst_n`).
- `DATA_WIDTH`, 32, datapath width.
- `RESET_PC`, 32'h8000_0000, PC loaded at reset.
- `TIMEOUT`, 255, maximum wait cycles in FETCH or MEM before error halt (8-bit counter).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start_i`  in  1  leave IDLE; ignored in all other states.
- `ifu_req_o`  out  1  instruction fetch request.
- `ifu_addr_o`  out  32  fetch address, equals PC.
- `ifu_rvalid_i`  in  1  fetch data valid.
- `ifu_rdata_i`  in  32  fetched instruction.
- `inst_o`  out  32  latched instruction to IDU/EXU.
- `inst_addr_o`  out  32  PC of `inst_o`.
- `jump_addr_i`  in  32  target computed by EXU.
- `branch_taken_i`  in  1  branch condition from EXU; sampled only for opcode 1100011.
- `ebreak_i`  in  1  EXU ebreak indication.
- `lsu_req_o`  out  1  data access request.
- `lsu_we_o`  out  1  1 = store, 0 = load; valid with `lsu_req_o`.
- `lsu_done_i`  in  1  data access complete.
- `rf_we_o`  out  1  register-file write enable, one-cycle pulse.
- `halt_o`  out  1  core halted (sticky).
- `err_o`  out  1  halt caused by error (sticky).
- `cycle_cnt_o`  out  32  active-cycle counter.
- `instret_o`  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, EXEC, MEM, WB, HALT.
- IDLE → FETCH on `start_i`.
- FETCH: `ifu_req_o` = 1 and is held until `ifu_rvalid_i`. On `ifu_rvalid_i`, `ifu_rdata_i` is latched into `inst_o` and the state moves to EXEC.
- EXEC: the opcode `inst_o[6:0]` is decoded.
  - `ebreak_i` = 1 → HALT, `err_o` = 0.
  - Opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011} → HALT, `err_o` = 1.
  - Load 0000011 or store 0100011 → MEM.
  - Otherwise → WB.
- MEM: `lsu_req_o` = 1 and is held until `lsu_done_i`. `lsu_we_o` = 1 for a store. On `lsu_done_i` → WB.
- WB: lasts one cycle.
  - `rf_we_o` = 1 unless the opcode is store, branch or system.
  - `instret_o` increments.
  - PC update, then → FETCH:
    - JAL: PC ← `jump_addr_i`.
    - JALR: PC ← {`jump_addr_i`[31:1], 0}.
    - Branch with `branch_taken_i` = 1: PC ← `jump_addr_i`.
    - Otherwise: PC ← PC + 4, wrapping modulo 2^32.
  - If the new PC has bits [1:0] ≠ 0, the next state is HALT with `err_o` = 1 instead of FETCH.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each waiting cycle. When it reaches `TIMEOUT` without a response, the state goes to HALT with `err_o` = 1 and the request drops.
- HALT: absorbing until reset. All requests and `rf_we_o` are 0, and `halt_o` = 1.
- `ifu_rvalid_i` outside FETCH and `lsu_done_i` outside MEM are ignored.
- `cycle_cnt_o` increments in every cycle that is not IDLE and not HALT, wrapping at 2^32.

## Timing
- Reset values:
  - State IDLE.
  - PC = `RESET_PC`.
  - `inst_o` = 0 and `inst_addr_o` = `RESET_PC`.
  - `ifu_req_o`, `lsu_req_o`, `lsu_we_o`, `rf_we_o`, `halt_o` and `err_o` = 0.
  - Both counters = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `*_i` to `*_req_o`.
- Minimum latency per instruction:
  - Non-memory: 3 cycles (FETCH, EXEC, WB), when `ifu_rvalid_i` is high in the first FETCH cycle.
  - Memory: 4 cycles.
- `inst_o` and `inst_addr_o` are stable from the cycle after the fetch handshake through the end of WB.
- `rf_we_o` is high for exactly one cycle per writing instruction.
- `rst_n` low in any state, including mid-handshake, forces the reset values on the next edge. Requests drop in that same edge.

## Test plan
- Reset, `start_i`, then fetch `addi` (0x00100093) with immediate rvalid: `ifu_addr_o` = 0x8000_0000; `rf_we_o` pulses on cycle 3; next fetch at 0x8000_0004; `instret_o` = 1.
- JAL with `jump_addr_i` = 0x8000_0100: next `ifu_addr_o` = 0x8000_0100. JALR with `jump_addr_i` = 0x8000_0203: next PC = 0x8000_0202.
- Load with `lsu_done_i` delayed 5 cycles: `lsu_req_o` high for 6 cycles and `lsu_we_o` = 0, then `rf_we_o` pulses. A store gives `lsu_we_o` = 1 and no `rf_we_o`.
- `ebreak` (0x00100073) with `ebreak_i` = 1: `halt_o` = 1 and `err_o` = 0 the cycle after EXEC. Further `start_i` and `ifu_rvalid_i` are ignored and `cycle_cnt_o` freezes.
- Illegal opcode 0x0000007F → `halt_o` = `err_o` = 1. A fetch with `ifu_rvalid_i` never asserted → halt with `err_o` after 255 wait cycles.
- Assert `rst_n` = 0 during MEM: on the next edge, `lsu_req_o` = 0, state IDLE, and PC = 0x8000_0000.

Source files
------------

// File: rtl/ysyx_24090018_exec_ctrl.sv
// Multi-cycle sequencing controller: owns the PC, fetches over a req/valid handshake,
// waits on load/store completion, commits write-back and next PC, halts on ebreak/error.
module ysyx_24090018_exec_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  ifu_req_o,
  output logic [DATA_WIDTH-1:0] ifu_addr_o,
  input  logic                  ifu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ifu_rdata_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_addr_o,
  input  logic [DATA_WIDTH-1:0] jump_addr_i,
  input  logic                  branch_taken_i,
  input  logic                  ebreak_i,
  output logic                  lsu_req_o,
  output logic                  lsu_we_o,
  input  logic                  lsu_done_i,
  output logic                  rf_we_o,
  output logic                  halt_o,
  output logic                  err_o,
  output logic [31:0]           cycle_cnt_o,
  output logic [31:0]           instret_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0]            WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] inst, inst_nxt;
  logic [DATA_WIDTH-1:0] inst_addr, inst_addr_nxt;
  logic [7:0]            wait_cnt, wait_nxt;
  logic                  err, err_nxt;
  logic [31:0]           cycle_cnt, instret;

  logic [6:0] opcode;
  logic       op_legal;
  logic       op_no_wb;

  assign opcode   = inst[6:0];
  assign op_no_wb = (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_SYSTEM);

  always_comb begin
    case (opcode)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  end

  // Next-state and datapath-register updates; the wait counter is cleared on every
  // entry to FETCH or MEM so each handshake gets its own timeout budget.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    inst_nxt      = inst;
    inst_addr_nxt = inst_addr;
    wait_nxt      = wait_cnt;
    err_nxt       = err;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_FETCH;
          wait_nxt  = 8'd0;
        end
      end
      S_FETCH: begin
        if (ifu_rvalid_i) begin
          inst_nxt      = ifu_rdata_i;
          inst_addr_nxt = pc;
          state_nxt     = S_EXEC;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (ebreak_i) begin
          state_nxt = S_HALT;
        end else if (!op_legal) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_nxt = S_MEM;
          wait_nxt  = 8'd0;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_done_i) begin
          state_nxt = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        if (opcode == OP_JAL) begin
          pc_nxt = jump_addr_i;
        end else if (opcode == OP_JALR) begin
          pc_nxt = {jump_addr_i[DATA_WIDTH-1:1], 1'b0};
        end else if ((opcode == OP_BRANCH) && branch_taken_i) begin
          pc_nxt = jump_addr_i;
        end else begin
          pc_nxt = pc + PC_STEP;
        end
        // A misaligned target still lands in the PC so it is visible after the halt.
        if (pc_nxt[1:0] != 2'b00) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = S_FETCH;
          wait_nxt  = 8'd0;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= '0;
      inst_addr <= RESET_PC;
      wait_cnt  <= 8'd0;
      err       <= 1'b0;
      cycle_cnt <= 32'd0;
      instret   <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      inst      <= inst_nxt;
      inst_addr <= inst_addr_nxt;
      wait_cnt  <= wait_nxt;
      err       <= err_nxt;
      if ((state != S_IDLE) && (state != S_HALT)) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (state == S_WB) begin
        instret <= instret + 32'd1;
      end
    end
  end

  assign ifu_req_o   = (state == S_FETCH);
  assign ifu_addr_o  = pc;
  assign inst_o      = inst;
  assign inst_addr_o = inst_addr;
  assign lsu_req_o   = (state == S_MEM);
  assign lsu_we_o    = (state == S_MEM) && (opcode == OP_STORE);
  assign rf_we_o     = (state == S_WB) && !op_no_wb;
  assign halt_o      = (state == S_HALT);
  assign err_o       = err;
  assign cycle_cnt_o = cycle_cnt;
  assign instret_o   = instret;

endmodule
